// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel button path: button indices,
// repeat-phase encoding and the fixed-priority grant helper.
package panel_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic {
    REP_DELAY  = 1'b0,
    REP_PERIOD = 1'b1
  } rep_phase_e;

  // Lowest index wins, so left beats right beats up beats down.
  function automatic logic [NUM_BTN-1:0] lowest_set(input logic [NUM_BTN-1:0] req);
    return req & (~req + NUM_BTN'(1));
  endfunction

endpackage

// File: rtl/panel_buttons_if.sv
// Bundle of the raw button inputs and conditioned command outputs seen
// between the board and the front-panel renderer.
interface panel_buttons_if;
  import panel_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic               left;
  logic               right;
  logic               up;
  logic               down;
  logic [NUM_BTN-1:0] held;

  modport master (output btn_raw, input left, right, up, down, held);
  modport slave  (input btn_raw, output left, right, up, down, held);

endinterface

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser, debounce counter, stable level and an
// optional auto-repeat counter; emits a registered one-cycle event strobe.
module button_debounce
  import panel_pkg::*;
#(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic event_strobe
);

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LIMIT     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LIMIT  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LIMIT = CNT_W'(REPEAT_PERIOD);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  rep_phase_e       rep_phase_q, rep_phase_d;
  logic             event_q, event_d;
  logic [CNT_W-1:0] rep_target;
  logic             rep_fire;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;

    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q >= DB_LIMIT - ONE) begin
      stable_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + ONE;
    end

    // Repeat only counts while the level is high and not about to fall, so a
    // release edge can never coincide with a final repeat strobe.
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    rep_target  = (rep_phase_q == REP_DELAY) ? DELAY_LIMIT : PERIOD_LIMIT;
    if (!REPEAT_EN || !(stable_q && stable_d)) begin
      rep_cnt_d   = '0;
      rep_phase_d = REP_DELAY;
    end else if (rep_cnt_q >= rep_target - ONE) begin
      rep_cnt_d   = '0;
      rep_phase_d = REP_PERIOD;
      rep_fire    = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + ONE;
    end

    event_d = (stable_d & ~stable_q) | rep_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      stable_q    <= 1'b0;
      rep_cnt_q   <= '0;
      rep_phase_q <= REP_DELAY;
      event_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      stable_q    <= stable_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      event_q     <= event_d;
    end
  end

  assign stable       = stable_q;
  assign event_strobe = event_q;

endmodule

// File: rtl/panel_buttons.sv
// Front-panel button conditioner: four debounced buttons feeding a pending
// set and a fixed-priority arbiter that issues at most one command per clock.
module panel_buttons
  import panel_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 REPEAT_DELAY    = 12500000,
  parameter int                 REPEAT_PERIOD   = 2500000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0011,
  parameter int                 CNT_W           = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               left,
  output logic               right,
  output logic               up,
  output logic               down,
  output logic [NUM_BTN-1:0] held
);

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] event_strobe;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] cmd_q, cmd_d;
  logic [NUM_BTN-1:0] held_q, held_d;
  logic [NUM_BTN-1:0] grant;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[i]),
      .stable       (stable[i]),
      .event_strobe (event_strobe[i])
    );
  end

  // A fresh event on a bit being granted this cycle re-arms it rather than being lost.
  always_comb begin
    grant     = lowest_set(pending_q);
    pending_d = (pending_q & ~grant) | event_strobe;
    cmd_d     = grant;
    held_d    = stable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      cmd_q     <= '0;
      held_q    <= '0;
    end else begin
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      held_q    <= held_d;
    end
  end

  assign left  = cmd_q[BTN_LEFT];
  assign right = cmd_q[BTN_RIGHT];
  assign up    = cmd_q[BTN_UP];
  assign down  = cmd_q[BTN_DOWN];
  assign held  = held_q;

endmodule

// File: tb/tb_panel_buttons.sv
// Scoreboard bench for panel_buttons: expected command pulses are queued as
// each stimulus is applied and matched against pulses seen on the outputs.
module tb_panel_buttons;
  import panel_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
  } pulse_t;

  logic   clk = 1'b0;
  logic   reset;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  pulse_t sbQ[$];

  panel_buttons_if bus ();

  panel_buttons #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_MASK     (4'b0011),
    .CNT_W           (24)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_raw),
    .left    (bus.left),
    .right   (bus.right),
    .up      (bus.up),
    .down    (bus.down),
    .held    (bus.held)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge when read at a negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btns);
    bus.btn_raw = btns;
  endtask

  task automatic expectPulse(input int atCyc, input logic [3:0] cmd);
    pulse_t p;
    p.cyc = atCyc;
    p.cmd = cmd;
    sbQ.push_back(p);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] cmdNow;
    pulse_t     expPulse;
    cmdNow = {bus.down, bus.up, bus.right, bus.left};
    if (cmdNow != 4'b0000) begin
      checkOutput("onehot", 32'($onehot(cmdNow)), 32'd1);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(cmdNow), 32'd0);
      end else begin
        expPulse = sbQ.pop_front();
        checkOutput("pulse_cycle", 32'(cyc), 32'(expPulse.cyc));
        checkOutput("pulse_cmd", 32'(cmdNow), 32'(expPulse.cmd));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    reset = 1'b1;
    applyStimulus(4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd", 32'({bus.down, bus.up, bus.right, bus.left}), 32'd0);
    checkOutput("reset_held", 32'(bus.held), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single left press held for ten samples.
    t0 = cyc + 1;
    applyStimulus(4'b0001);
    expectPulse(t0 + 7, 4'b0001);
    waitUntil(t0 + 5);
    checkOutput("t1_held_before", 32'(bus.held), 32'd0);
    waitUntil(t0 + 6);
    checkOutput("t1_held_after", 32'(bus.held), 32'h1);
    waitUntil(t0 + 9);
    applyStimulus(4'b0000);
    waitUntil(t0 + 25);
    checkOutput("t1_released", 32'(bus.held), 32'd0);
    checkOutput("t1_drained", 32'(sbQ.size()), 32'd0);

    // Bouncing up: 1,0,1,0 then steady high from the fifth sample.
    @(negedge clk);
    t0 = cyc + 1;
    applyStimulus(4'b0100);
    @(negedge clk) applyStimulus(4'b0000);
    @(negedge clk) applyStimulus(4'b0100);
    @(negedge clk) applyStimulus(4'b0000);
    @(negedge clk) applyStimulus(4'b0100);
    expectPulse(t0 + 11, 4'b0100);
    waitUntil(t0 + 8);
    checkOutput("t2_held_bounce", 32'(bus.held), 32'd0);
    waitUntil(t0 + 10);
    checkOutput("t2_held_settled", 32'(bus.held), 32'h4);
    waitUntil(t0 + 15);
    applyStimulus(4'b0000);
    waitUntil(t0 + 35);
    checkOutput("t2_drained", 32'(sbQ.size()), 32'd0);

    // Right held 60 samples: initial pulse plus repeats at +20 then every 8.
    t0 = cyc + 1;
    applyStimulus(4'b0010);
    expectPulse(t0 + 7, 4'b0010);
    for (int k = 0; k < 5; k++) expectPulse(t0 + 27 + 8 * k, 4'b0010);
    waitUntil(t0 + 59);
    applyStimulus(4'b0000);
    waitUntil(t0 + 90);
    checkOutput("t3_right_drained", 32'(sbQ.size()), 32'd0);
    checkOutput("t3_right_held", 32'(bus.held), 32'd0);

    // Down has no repeat enable: one pulse only.
    t0 = cyc + 1;
    applyStimulus(4'b1000);
    expectPulse(t0 + 7, 4'b1000);
    waitUntil(t0 + 59);
    applyStimulus(4'b0000);
    waitUntil(t0 + 90);
    checkOutput("t3_down_drained", 32'(sbQ.size()), 32'd0);

    // All four at once: arbitrated over four consecutive cycles.
    t0 = cyc + 1;
    applyStimulus(4'b1111);
    expectPulse(t0 + 7, 4'b0001);
    expectPulse(t0 + 8, 4'b0010);
    expectPulse(t0 + 9, 4'b0100);
    expectPulse(t0 + 10, 4'b1000);
    waitUntil(t0 + 7);
    checkOutput("t4_held_all", 32'(bus.held), 32'hF);
    waitUntil(t0 + 9);
    applyStimulus(4'b0000);
    waitUntil(t0 + 30);
    checkOutput("t4_drained", 32'(sbQ.size()), 32'd0);
    checkOutput("t4_held_none", 32'(bus.held), 32'd0);

    // Reset mid-debounce with left held throughout.
    t0 = cyc + 1;
    applyStimulus(4'b0001);
    waitUntil(t0 + 2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_cmd", 32'({bus.down, bus.up, bus.right, bus.left}), 32'd0);
    checkOutput("t5_reset_held", 32'(bus.held), 32'd0);
    reset = 1'b0;
    expectPulse(t0 + 11, 4'b0001);
    waitUntil(t0 + 10);
    checkOutput("t5_held_fresh", 32'(bus.held), 32'h1);
    waitUntil(t0 + 15);
    applyStimulus(4'b0000);
    waitUntil(t0 + 35);
    checkOutput("t5_drained", 32'(sbQ.size()), 32'd0);

    // Three-sample glitch on right must be rejected.
    t0 = cyc + 1;
    applyStimulus(4'b0010);
    waitUntil(t0 + 2);
    applyStimulus(4'b0000);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("t6_held_glitch", 32'(bus.held), 32'd0);
    end
    checkOutput("t6_drained", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
